// File: rtl/asg_seq_pkg.sv
// Shared definitions for the ASG config sequencer.
// Contents: field widths, slot-state enum, slot and global word offsets.
package asg_seq_pkg;

  localparam int unsigned AMP_W = 14;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DLY_W = 32;

  typedef enum logic [1:0] {
    SLOT_EMPTY  = 2'd0,
    SLOT_LOADED = 2'd1,
    SLOT_ACTIVE = 2'd2
  } slot_state_e;

  // Word offsets inside one 0x20-byte slot window (byte offset >> 2)
  localparam logic [2:0] W_AMP    = 3'd0;
  localparam logic [2:0] W_DC     = 3'd1;
  localparam logic [2:0] W_START  = 3'd2;
  localparam logic [2:0] W_END    = 3'd3;
  localparam logic [2:0] W_STEP   = 3'd4;
  localparam logic [2:0] W_CYC    = 3'd5;
  localparam logic [2:0] W_RDLY   = 3'd6;
  localparam logic [2:0] W_COMMIT = 3'd7;

  // Word offsets inside the global window at 0x80
  localparam logic [1:0] G_CTRL   = 2'd0;
  localparam logic [1:0] G_STATUS = 2'd1;
  localparam logic [1:0] G_IRQ    = 2'd2;
  localparam logic [1:0] G_CNT    = 2'd3;

endpackage

// File: rtl/asg_seq_slot.sv
// One config slot: field registers, EMPTY/LOADED/ACTIVE state, write acceptance.
// Ports: clk_i/rst_ni clock and async active-low reset; wr_i/word_i/wdata_i
// decoded bus write into this slot; activate_i/release_i/demote_i state
// commands from the sequencer; *_o field values, state_o, busy_o (writes
// rejected), commit_o (accepted commit this cycle), rdata_o read mux.
module asg_seq_slot
  import asg_seq_pkg::*;
#(
  parameter int unsigned RSZ = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_i,
  input  logic [2:0]           word_i,
  input  logic [31:0]          wdata_i,
  input  logic                 activate_i,
  input  logic                 release_i,
  input  logic                 demote_i,
  output logic [AMP_W-1:0]     amp_o,
  output logic [AMP_W-1:0]     dc_o,
  output logic [RSZ+15:0]      start_o,
  output logic [RSZ+15:0]      end_o,
  output logic [RSZ+15:0]      step_o,
  output logic [CNT_W-1:0]     ncyc_o,
  output logic [CNT_W-1:0]     rnum_o,
  output logic [DLY_W-1:0]     rdly_o,
  output slot_state_e          state_o,
  output logic                 busy_o,
  output logic                 commit_o,
  output logic [31:0]          rdata_o
);

  localparam int unsigned PW = RSZ + 16;

  logic [AMP_W-1:0] amp_q, dc_q;
  logic [PW-1:0]    start_q, end_q, step_q;
  logic [CNT_W-1:0] ncyc_q, rnum_q;
  logic [DLY_W-1:0] rdly_q;
  slot_state_e      state_q, state_d;
  logic             wr_ok;

  assign busy_o   = (state_q == SLOT_ACTIVE);
  assign wr_ok    = wr_i & ~busy_o;
  assign commit_o = wr_i & (word_i == W_COMMIT) & wdata_i[0] & (state_q == SLOT_EMPTY);

  // Activation may coincide with a same-cycle commit, so it takes priority.
  always_comb begin
    state_d = state_q;
    if (activate_i)                               state_d = SLOT_ACTIVE;
    else if (release_i)                           state_d = SLOT_EMPTY;
    else if (demote_i && state_q == SLOT_ACTIVE)  state_d = SLOT_LOADED;
    else if (commit_o)                            state_d = SLOT_LOADED;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
      amp_q   <= '0;
      dc_q    <= '0;
      start_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      ncyc_q  <= '0;
      rnum_q  <= '0;
      rdly_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_ok) begin
        case (word_i)
          W_AMP:   amp_q   <= wdata_i[AMP_W-1:0];
          W_DC:    dc_q    <= wdata_i[AMP_W-1:0];
          W_START: start_q <= wdata_i[PW-1:0];
          W_END:   end_q   <= wdata_i[PW-1:0];
          W_STEP:  step_q  <= wdata_i[PW-1:0];
          W_CYC: begin
            ncyc_q <= wdata_i[15:0];
            rnum_q <= wdata_i[31:16];
          end
          W_RDLY:  rdly_q  <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (word_i)
      W_AMP:   rdata_o = 32'(amp_q);
      W_DC:    rdata_o = 32'(dc_q);
      W_START: rdata_o = 32'(start_q);
      W_END:   rdata_o = 32'(end_q);
      W_STEP:  rdata_o = 32'(step_q);
      W_CYC:   rdata_o = {rnum_q, ncyc_q};
      W_RDLY:  rdata_o = rdly_q;
      default: rdata_o = '0;
    endcase
  end

  assign amp_o   = amp_q;
  assign dc_o    = dc_q;
  assign start_o = start_q;
  assign end_o   = end_q;
  assign step_o  = step_q;
  assign ncyc_o  = ncyc_q;
  assign rnum_o  = rnum_q;
  assign rdly_o  = rdly_q;
  assign state_o = state_q;

endmodule

// File: rtl/red_pitaya_asg_seq_cfg.sv
// Multi-buffer ASG config sequencer.
// Holds N_BUF config slots written over the sys bus, drives the packed
// set_*_all buses, advances the active slot on buf_done_i and frees finished
// slots (flagging underrun when the next slot is not loaded).
// Ports: dac_clk_i/dac_rstn_i clock and async active-low reset; sys_* bus
// (1-cycle registered ack/err/rdata); buf_done_i/cyc_done_i channel events;
// set_*_all_o per-slot fields; set_rst_o/set_zero_o channel control;
// active_slot_o playing slot; irq_o slot-freed interrupt.
module red_pitaya_asg_seq_cfg
  import asg_seq_pkg::*;
#(
  parameter int unsigned RSZ   = 14,
  parameter int unsigned N_BUF = 4,
  parameter int unsigned AW    = 8
) (
  input  logic                      dac_clk_i,
  input  logic                      dac_rstn_i,
  input  logic                      sys_wen_i,
  input  logic                      sys_ren_i,
  input  logic [AW-1:0]             sys_addr_i,
  input  logic [31:0]               sys_wdata_i,
  output logic [31:0]               sys_rdata_o,
  output logic                      sys_ack_o,
  output logic                      sys_err_o,
  input  logic                      buf_done_i,
  input  logic                      cyc_done_i,
  output logic [AMP_W*N_BUF-1:0]    set_amp_all_o,
  output logic [AMP_W*N_BUF-1:0]    set_dc_all_o,
  output logic [(RSZ+16)*N_BUF-1:0] set_end_all_o,
  output logic [(RSZ+16)*N_BUF-1:0] set_step_all_o,
  output logic [(RSZ+16)*N_BUF-1:0] set_start_all_o,
  output logic [CNT_W*N_BUF-1:0]    set_ncyc_all_o,
  output logic [CNT_W*N_BUF-1:0]    set_rnum_all_o,
  output logic [DLY_W*N_BUF-1:0]    set_rdly_all_o,
  output logic                      set_rst_o,
  output logic                      set_zero_o,
  output logic [1:0]                active_slot_o,
  output logic                      irq_o
);

  localparam int unsigned PW = RSZ + 16;

  // Address decode
  logic       is_slot, is_glb;
  logic [1:0] slot_sel, gidx;
  logic [2:0] word;
  logic       unused_addr;

  assign is_slot     = (sys_addr_i >> 7) == '0;
  assign is_glb      = (sys_addr_i >> 4) == AW'(8);
  assign slot_sel    = sys_addr_i[6:5];
  assign word        = sys_addr_i[4:2];
  assign gidx        = sys_addr_i[3:2];
  assign unused_addr = ^sys_addr_i[1:0];

  // Slot array
  slot_state_e      st     [N_BUF];
  logic [31:0]      srd    [N_BUF];
  logic [N_BUF-1:0] slot_wr, busy, commit, activate, rel, demote, valid;

  always_comb begin
    for (int unsigned k = 0; k < N_BUF; k++) begin
      slot_wr[k] = sys_wen_i & is_slot & (slot_sel == 2'(k));
      valid[k]   = (st[k] != SLOT_EMPTY);
    end
  end

  for (genvar k = 0; k < N_BUF; k++) begin : g_slot
    asg_seq_slot #(.RSZ(RSZ)) u_slot (
      .clk_i      (dac_clk_i),
      .rst_ni     (dac_rstn_i),
      .wr_i       (slot_wr[k]),
      .word_i     (word),
      .wdata_i    (sys_wdata_i),
      .activate_i (activate[k]),
      .release_i  (rel[k]),
      .demote_i   (demote[k]),
      .amp_o      (set_amp_all_o[AMP_W*k +: AMP_W]),
      .dc_o       (set_dc_all_o[AMP_W*k +: AMP_W]),
      .start_o    (set_start_all_o[PW*k +: PW]),
      .end_o      (set_end_all_o[PW*k +: PW]),
      .step_o     (set_step_all_o[PW*k +: PW]),
      .ncyc_o     (set_ncyc_all_o[CNT_W*k +: CNT_W]),
      .rnum_o     (set_rnum_all_o[CNT_W*k +: CNT_W]),
      .rdly_o     (set_rdly_all_o[DLY_W*k +: DLY_W]),
      .state_o    (st[k]),
      .busy_o     (busy[k]),
      .commit_o   (commit[k]),
      .rdata_o    (srd[k])
    );
  end

  // Sequencer state
  logic        run_q, run_d, rst_q, rst_d, underrun_q, underrun_d, en_q, en_d;
  logic [1:0]  active_q, active_d, nxt;
  logic [3:0]  pend_q, pend_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ack_q, err_q, err_d, set_rst_q, set_zero_q;
  logic [31:0] rdata_q, rdata_d;
  logic        ctrl_wr, irq_wr, playing;

  assign ctrl_wr = sys_wen_i & is_glb & (gidx == G_CTRL);
  assign irq_wr  = sys_wen_i & is_glb & (gidx == G_IRQ);
  assign playing = run_q & ~rst_q;
  assign nxt     = active_q + 2'd1;

  // A control write takes precedence over channel events in the same cycle;
  // buf_done may still activate a slot that is being committed right now.
  always_comb begin
    run_d      = run_q;
    rst_d      = rst_q;
    active_d   = active_q;
    underrun_d = underrun_q;
    pend_d     = pend_q;
    en_d       = en_q;
    cnt_d      = cnt_q;
    activate   = '0;
    rel        = '0;
    demote     = '0;
    if (irq_wr) begin
      en_d   = sys_wdata_i[4];
      pend_d = pend_q & ~sys_wdata_i[3:0];
    end
    if (ctrl_wr) begin
      run_d = sys_wdata_i[0];
      rst_d = sys_wdata_i[1];
      if (sys_wdata_i[1]) begin
        active_d   = '0;
        underrun_d = 1'b0;
        pend_d     = '0;
      end
      if (!(sys_wdata_i[0] && !sys_wdata_i[1])) begin
        demote = '1;
      end else if (!playing) begin
        active_d = '0;
        cnt_d    = '0;
        if (st[0] == SLOT_LOADED) begin
          activate[0] = 1'b1;
          underrun_d  = 1'b0;
        end else begin
          underrun_d  = 1'b1;
        end
      end
    end else if (playing) begin
      if (buf_done_i) begin
        rel[active_q]    = 1'b1;
        pend_d[active_q] = 1'b1;
        active_d         = nxt;
        if (st[nxt] == SLOT_LOADED || commit[nxt]) activate[nxt] = 1'b1;
        else                                       underrun_d    = 1'b1;
      end
      if (cyc_done_i && cnt_q != '1) cnt_d = cnt_q + 32'd1;
    end
  end

  always_comb begin
    err_d   = (sys_wen_i | sys_ren_i) & ~is_slot & ~is_glb;
    err_d   = err_d | (sys_wen_i & is_slot & busy[slot_sel]);
    rdata_d = '0;
    if (sys_ren_i) begin
      if (is_slot) begin
        rdata_d = srd[slot_sel];
      end else if (is_glb) begin
        case (gidx)
          G_CTRL:   rdata_d = {30'd0, rst_q, run_q};
          G_STATUS: rdata_d = {23'd0, underrun_q, 2'd0, active_q, valid};
          G_IRQ:    rdata_d = {27'd0, en_q, pend_q};
          G_CNT:    rdata_d = cnt_q;
          default:  rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      run_q      <= 1'b0;
      rst_q      <= 1'b0;
      active_q   <= '0;
      underrun_q <= 1'b0;
      pend_q     <= '0;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      set_rst_q  <= 1'b0;
      set_zero_q <= 1'b0;
    end else begin
      run_q      <= run_d;
      rst_q      <= rst_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      cnt_q      <= cnt_d;
      ack_q      <= sys_wen_i | sys_ren_i;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      set_rst_q  <= rst_d | ~run_d;
      set_zero_q <= underrun_d | ~run_d;
    end
  end

  assign sys_ack_o     = ack_q;
  assign sys_err_o     = err_q;
  assign sys_rdata_o   = rdata_q;
  assign set_rst_o     = set_rst_q;
  assign set_zero_o    = set_zero_q;
  assign active_slot_o = active_q;
  assign irq_o         = en_q & (|pend_q);

endmodule
